// File: rtl/sdram_ref_sched_if.sv
// Handshake and command-bus bundle between the refresh scheduler and the SDRAM arbiter.
// sr_req exists only when SDRAM_REF_SELF_REFRESH_EN is defined.
interface sdram_ref_sched_if #(
   parameter int A_W  = 13,
   parameter int BA_W = 2
);
   localparam int BUS_W = 4 + A_W + BA_W + 1;

   logic             ref_en;
   logic             ref_req;
   logic             ref_grant;
   logic             ref_busy;
   logic             ref_done;
   logic             ref_urgent;
   logic             ref_ovf;
   logic [BUS_W-1:0] ref_bus;
`ifdef SDRAM_REF_SELF_REFRESH_EN
   logic             sr_req;

   modport master (
      input  ref_en, ref_grant, sr_req,
      output ref_req, ref_busy, ref_done, ref_urgent, ref_ovf, ref_bus
   );
   modport slave (
      output ref_en, ref_grant, sr_req,
      input  ref_req, ref_busy, ref_done, ref_urgent, ref_ovf, ref_bus
   );
`else
   modport master (
      input  ref_en, ref_grant,
      output ref_req, ref_busy, ref_done, ref_urgent, ref_ovf, ref_bus
   );
   modport slave (
      output ref_en, ref_grant,
      input  ref_req, ref_busy, ref_done, ref_urgent, ref_ovf, ref_bus
   );
`endif
endinterface

// File: rtl/sdram_ref_sched.sv
// SDRAM auto-refresh scheduler: tREFI credit timer, pending-credit counter and PRE + REF-burst sequencer.
// Self-refresh entry/exit is added when SDRAM_REF_SELF_REFRESH_EN is defined.
module sdram_ref_sched #(
   parameter int A_W       = 13,
   parameter int BA_W      = 2,
   parameter int TRP       = 3,
   parameter int TRFC      = 7,
   parameter int TREFI     = 780,
   parameter int MAX_PEND  = 8,
   parameter int BURST_MAX = 8,
   parameter int CNT_W     = 16
`ifdef SDRAM_REF_SELF_REFRESH_EN
   ,
   parameter int TXSR      = 10
`endif
) (
   input logic               clk,
   input logic               soft_rst_n,
   sdram_ref_sched_if.master rif
);

   localparam logic [3:0]       CMD_NOP     = 4'b0111;
   localparam logic [3:0]       CMD_PRE     = 4'b0010;
   localparam logic [3:0]       CMD_REF     = 4'b0001;
   localparam logic [A_W-1:0]   A_ALL_BANKS = {{(A_W-11){1'b0}}, 1'b1, 10'b0};
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TREFI_LAST  = CNT_W'(TREFI - 1);
   // Wait counters run 0..N-2 so that the wait state lasts N-1 cycles.
   localparam logic [CNT_W-1:0] TRP_LAST    = CNT_W'(TRP - 2);
   localparam logic [CNT_W-1:0] TRFC_LAST   = CNT_W'(TRFC - 2);
   localparam logic [CNT_W-1:0] BURST_LIM   = CNT_W'(BURST_MAX);
   localparam logic [3:0]       PEND_MAX    = 4'(MAX_PEND);

`ifdef SDRAM_REF_SELF_REFRESH_EN
   localparam logic [CNT_W-1:0] TXSR_LAST   = CNT_W'(TXSR - 1);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_PRE = 3'd1, S_TRP_W = 3'd2, S_REF = 3'd3,
      S_TRFC_W = 3'd4, S_DONE = 3'd5, S_SR_HOLD = 3'd6, S_SR_EXIT = 3'd7
   } state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_PRE = 3'd1, S_TRP_W = 3'd2, S_REF = 3'd3,
      S_TRFC_W = 3'd4, S_DONE = 3'd5
   } state_e;
`endif

   state_e           state_r;
   logic [CNT_W-1:0] timer_r;
   logic [CNT_W-1:0] wait_r;
   logic [CNT_W-1:0] burst_r;
   logic [3:0]       pend_r;
   logic [3:0]       cmd_r;
   logic [A_W-1:0]   a_r;
   logic [BA_W-1:0]  ba_r;
   logic             cke_r;
   logic             req_r;
   logic             busy_r;
   logic             done_r;
   logic             urgent_r;
   logic             ovf_r;

   logic             hold_s;
   logic             sr_go_s;
   logic             cke_ref_s;
   logic             timer_run_s;
   logic             tick_s;
   logic             ref_issue_s;
   logic             ovf_set_s;
   logic             more_ref_s;
   logic             idle_req_s;
   logic [3:0]       pend_nx_s;
   logic [CNT_W-1:0] burst_nx_s;

`ifdef SDRAM_REF_SELF_REFRESH_EN
   logic             sr_mode_r;

   // Remember that the running sequence is a self-refresh entry rather than a refresh burst.
   always_ff @(posedge clk or negedge soft_rst_n) begin
      if (!soft_rst_n) begin
         sr_mode_r <= 1'b0;
      end else if (state_r == S_IDLE && rif.sr_req) begin
         sr_mode_r <= 1'b1;
      end else if (state_r == S_DONE) begin
         sr_mode_r <= 1'b0;
      end else begin
         sr_mode_r <= sr_mode_r;
      end
   end

   assign hold_s    = (state_r == S_SR_HOLD);
   assign sr_go_s   = rif.sr_req;
   assign cke_ref_s = ~sr_mode_r;
   assign ref_issue_s = (state_r == S_REF) && (pend_r != 4'd0) && !sr_mode_r;
`else
   assign hold_s    = 1'b0;
   assign sr_go_s   = 1'b0;
   assign cke_ref_s = 1'b1;
   assign ref_issue_s = (state_r == S_REF) && (pend_r != 4'd0);
`endif

   assign timer_run_s = rif.ref_en && !hold_s;
   assign tick_s      = timer_run_s && (timer_r == TREFI_LAST);
   assign burst_nx_s  = (state_r == S_REF) ? (burst_r + CNT_ONE) : burst_r;
   assign more_ref_s  = (pend_nx_s != 4'd0) && (burst_nx_s < BURST_LIM);
   assign idle_req_s  = (pend_nx_s != 4'd0) && rif.ref_en;

   // Next credit count: a tick and an issued REF in the same cycle cancel out.
   always_comb begin
      pend_nx_s = pend_r;
      ovf_set_s = 1'b0;
      if (hold_s) begin
         pend_nx_s = 4'd0;
      end else if (tick_s && !ref_issue_s) begin
         if (pend_r == PEND_MAX) begin
            ovf_set_s = 1'b1;
         end else begin
            pend_nx_s = pend_r + 4'd1;
         end
      end else if (ref_issue_s && !tick_s) begin
         pend_nx_s = pend_r - 4'd1;
      end else begin
         pend_nx_s = pend_r;
      end
   end

   // tREFI interval timer; frozen rather than cleared while disabled.
   always_ff @(posedge clk or negedge soft_rst_n) begin
      if (!soft_rst_n) begin
         timer_r <= '0;
      end else if (tick_s) begin
         timer_r <= '0;
      end else if (timer_run_s) begin
         timer_r <= timer_r + CNT_ONE;
      end else begin
         timer_r <= timer_r;
      end
   end

   // Credit counter with urgency flag and sticky overflow.
   always_ff @(posedge clk or negedge soft_rst_n) begin
      if (!soft_rst_n) begin
         pend_r   <= 4'd0;
         urgent_r <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         pend_r   <= pend_nx_s;
         urgent_r <= (pend_nx_s == PEND_MAX);
         ovf_r    <= ovf_r | ovf_set_s;
      end
   end

   // Refresh sequencer; bus outputs are loaded with the values for the state being entered.
   always_ff @(posedge clk or negedge soft_rst_n) begin
      if (!soft_rst_n) begin
         state_r <= S_IDLE;
         wait_r  <= '0;
         burst_r <= '0;
         cmd_r   <= CMD_NOP;
         a_r     <= '0;
         ba_r    <= '0;
         cke_r   <= 1'b1;
         req_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         cmd_r   <= CMD_NOP;
         a_r     <= '0;
         ba_r    <= '0;
         cke_r   <= 1'b1;
         busy_r  <= 1'b1;
         done_r  <= 1'b0;
         req_r   <= 1'b0;
         wait_r  <= '0;
         burst_r <= burst_nx_s;
         case (state_r)
            S_IDLE: begin
               if (sr_go_s || (req_r && rif.ref_grant)) begin
                  state_r <= S_PRE;
                  cmd_r   <= CMD_PRE;
                  a_r     <= A_ALL_BANKS;
               end else begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
                  req_r   <= idle_req_s;
               end
            end
            S_PRE: begin
               if (TRP == 1) begin
                  state_r <= S_REF;
                  cmd_r   <= CMD_REF;
                  cke_r   <= cke_ref_s;
               end else begin
                  state_r <= S_TRP_W;
               end
            end
            S_TRP_W: begin
               if (wait_r == TRP_LAST) begin
                  state_r <= S_REF;
                  cmd_r   <= CMD_REF;
                  cke_r   <= cke_ref_s;
               end else begin
                  state_r <= S_TRP_W;
                  wait_r  <= wait_r + CNT_ONE;
               end
            end
            S_REF: begin
`ifdef SDRAM_REF_SELF_REFRESH_EN
               if (sr_mode_r) begin
                  state_r <= S_SR_HOLD;
                  cke_r   <= 1'b0;
               end else
`endif
               if (TRFC == 1) begin
                  if (more_ref_s) begin
                     state_r <= S_REF;
                     cmd_r   <= CMD_REF;
                  end else begin
                     state_r <= S_DONE;
                     done_r  <= 1'b1;
                  end
               end else begin
                  state_r <= S_TRFC_W;
               end
            end
            S_TRFC_W: begin
               if (wait_r == TRFC_LAST) begin
                  if (more_ref_s) begin
                     state_r <= S_REF;
                     cmd_r   <= CMD_REF;
                  end else begin
                     state_r <= S_DONE;
                     done_r  <= 1'b1;
                  end
               end else begin
                  state_r <= S_TRFC_W;
                  wait_r  <= wait_r + CNT_ONE;
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
               burst_r <= '0;
               req_r   <= idle_req_s;
            end
`ifdef SDRAM_REF_SELF_REFRESH_EN
            S_SR_HOLD: begin
               if (rif.sr_req) begin
                  state_r <= S_SR_HOLD;
                  cke_r   <= 1'b0;
               end else begin
                  state_r <= S_SR_EXIT;
               end
            end
            S_SR_EXIT: begin
               if (wait_r == TXSR_LAST) begin
                  state_r <= S_DONE;
                  done_r  <= 1'b1;
               end else begin
                  state_r <= S_SR_EXIT;
                  wait_r  <= wait_r + CNT_ONE;
               end
            end
`endif
            default: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
               burst_r <= '0;
            end
         endcase
      end
   end

   assign rif.ref_req    = req_r;
   assign rif.ref_busy   = busy_r;
   assign rif.ref_done   = done_r;
   assign rif.ref_urgent = urgent_r;
   assign rif.ref_ovf    = ovf_r;
   assign rif.ref_bus    = {cmd_r, a_r, ba_r, cke_r};

endmodule

// File: tb/tb_sdram_ref_sched.sv
// Bench for sdram_ref_sched: two instances (BURST_MAX 8 and 2) checked every cycle against a
// timeline model of the refresh schedule, with directed phases followed by random enable/grant.
module tb_sdram_ref_sched;

   localparam int TREFI    = 100;
   localparam int TRP      = 3;
   localparam int TRFC     = 7;
   localparam int MAX_PEND = 8;
   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] PRE = 4'b0010;
   localparam logic [3:0] REF = 4'b0001;
   localparam logic [24:0] RESET_VEC = {5'b00000, 4'b0111, 13'h0000, 2'b00, 1'b1};

   logic clk = 1'b0;
   logic soft_rst_n;
   always #5 clk = ~clk;

   sdram_ref_sched_if #(.A_W(13), .BA_W(2)) ifa ();
   sdram_ref_sched_if #(.A_W(13), .BA_W(2)) ifb ();

   sdram_ref_sched #(.A_W(13), .BA_W(2), .TRP(TRP), .TRFC(TRFC), .TREFI(TREFI),
                     .MAX_PEND(MAX_PEND), .BURST_MAX(8), .CNT_W(16))
      u_dut_a (.clk(clk), .soft_rst_n(soft_rst_n), .rif(ifa));
   sdram_ref_sched #(.A_W(13), .BA_W(2), .TRP(TRP), .TRFC(TRFC), .TREFI(TREFI),
                     .MAX_PEND(MAX_PEND), .BURST_MAX(2), .CNT_W(16))
      u_dut_b (.clk(clk), .soft_rst_n(soft_rst_n), .rif(ifb));

   logic [24:0] obs_a, obs_b;
   assign obs_a = {ifa.ref_req, ifa.ref_busy, ifa.ref_done, ifa.ref_urgent, ifa.ref_ovf, ifa.ref_bus};
   assign obs_b = {ifb.ref_req, ifb.ref_busy, ifb.ref_done, ifb.ref_urgent, ifb.ref_ovf, ifb.ref_bus};

   int n_vec = 0;
   int n_err = 0;

   // Model: per instance, credit arithmetic plus burst timeline relative to the PRE cycle.
   int bmax [2];
   int m_timer [2], m_pend [2], m_p [2], m_nrefs [2], m_next_ref [2], m_decide_p [2], m_done_p [2];
   bit m_active [2], m_ovf [2], m_req [2];
   int ref_cnt [2], done_cnt [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_timer[k] = 0; m_pend[k] = 0; m_p[k] = 0; m_nrefs[k] = 0;
         m_next_ref[k] = -1; m_decide_p[k] = -1; m_done_p[k] = -1;
         m_active[k] = 1'b0; m_ovf[k] = 1'b0; m_req[k] = 1'b0;
      end
   endtask

   function automatic logic [24:0] exp_vec(input int k);
      logic [3:0]  cmd;
      logic [12:0] a;
      logic        done;
      cmd = NOP;
      a   = 13'h0000;
      if (m_active[k] && m_p[k] == 0) begin
         cmd = PRE;
         a   = 13'h0400;
      end else if (m_active[k] && m_p[k] == m_next_ref[k]) begin
         cmd = REF;
      end
      done = m_active[k] && (m_p[k] == m_done_p[k]);
      return {m_req[k], m_active[k], done, (m_pend[k] == MAX_PEND), m_ovf[k], cmd, a, 2'b00, 1'b1};
   endfunction

   task automatic model_step(input int k, input bit en, input bit gr);
      bit tick, issue;
      int pend_new;
      tick = en && (m_timer[k] == TREFI - 1);
      if (tick) m_timer[k] = 0;
      else if (en) m_timer[k]++;
      issue = m_active[k] && (m_p[k] == m_next_ref[k]);
      pend_new = m_pend[k];
      if (tick && !issue) begin
         if (pend_new == MAX_PEND) m_ovf[k] = 1'b1;
         else pend_new++;
      end else if (issue && !tick) begin
         pend_new--;
      end
      m_pend[k] = pend_new;
      if (m_active[k]) begin
         if (issue) begin
            m_nrefs[k]++;
            m_next_ref[k] = -1;
            m_decide_p[k] = m_p[k] + TRFC - 1;
         end
         if (m_p[k] == m_decide_p[k]) begin
            if (pend_new != 0 && m_nrefs[k] < bmax[k]) m_next_ref[k] = m_p[k] + 1;
            else m_done_p[k] = m_p[k] + 1;
            m_decide_p[k] = -1;
         end
         if (m_p[k] == m_done_p[k]) m_active[k] = 1'b0;
         m_p[k]++;
      end else if (m_req[k] && gr) begin
         m_active[k] = 1'b1; m_p[k] = 0; m_nrefs[k] = 0;
         m_next_ref[k] = TRP; m_decide_p[k] = -1; m_done_p[k] = -1;
      end
      m_req[k] = !m_active[k] && (pend_new != 0) && en;
   endtask

   // One cycle: compare this cycle's outputs, apply inputs, advance the model, move to next negedge.
   task automatic step(input bit en, input bit gr);
      chk("cyc_a", {7'd0, obs_a}, {7'd0, exp_vec(0)});
      chk("cyc_b", {7'd0, obs_b}, {7'd0, exp_vec(1)});
      if (obs_a[19:16] == REF) ref_cnt[0]++;
      if (obs_b[19:16] == REF) ref_cnt[1]++;
      if (obs_a[22]) done_cnt[0]++;
      if (obs_b[22]) done_cnt[1]++;
      ifa.ref_en = en; ifb.ref_en = en;
      ifa.ref_grant = gr; ifb.ref_grant = gr;
      model_step(0, en, gr);
      model_step(1, en, gr);
      @(negedge clk);
   endtask

   task automatic clr_counts();
      for (int k = 0; k < 2; k++) begin
         ref_cnt[k] = 0;
         done_cnt[k] = 0;
      end
   endtask

   initial begin
      int found;
      bmax[0] = 8;
      bmax[1] = 2;
      soft_rst_n = 1'b0;
      ifa.ref_en = 1'b0; ifb.ref_en = 1'b0;
      ifa.ref_grant = 1'b0; ifb.ref_grant = 1'b0;
      model_reset();
      clr_counts();
      repeat (3) @(negedge clk);
      chk("reset_a", {7'd0, obs_a}, {7'd0, RESET_VEC});
      chk("reset_b", {7'd0, obs_b}, {7'd0, RESET_VEC});
      soft_rst_n = 1'b1;

      // Grant tied high: first credit after TREFI cycles, one single-REF burst.
      repeat (130) step(1'b1, 1'b1);
      chk("p1_refs_a", ref_cnt[0], 1);
      chk("p1_done_a", done_cnt[0], 1);

      // Four credits accumulate, then one burst (BURST_MAX 8) or two bursts (BURST_MAX 2).
      clr_counts();
      repeat (380) step(1'b1, 1'b0);
      repeat (60) step(1'b1, 1'b1);
      chk("p2_refs_a", ref_cnt[0], 4);
      chk("p2_done_a", done_cnt[0], 1);
      chk("p2_refs_b", ref_cnt[1], 4);
      chk("p2_done_b", done_cnt[1], 2);

      // Five credits: 5 REF in one burst vs. 2 + 2 + 1.
      clr_counts();
      repeat (435) step(1'b1, 1'b0);
      repeat (70) step(1'b1, 1'b1);
      chk("p3_refs_a", ref_cnt[0], 5);
      chk("p3_done_a", done_cnt[0], 1);
      chk("p3_refs_b", ref_cnt[1], 5);
      chk("p3_done_b", done_cnt[1], 3);

      // Saturation: eight credits raise urgent, the ninth sets overflow.
      repeat (800) step(1'b1, 1'b0);
      chk("urgent_a", ifa.ref_urgent, 1);
      chk("no_ovf_a", ifa.ref_ovf, 0);
      repeat (50) step(1'b1, 1'b0);
      chk("ovf_a", ifa.ref_ovf, 1);
      chk("ovf_b", ifb.ref_ovf, 1);
      repeat (150) step(1'b1, 1'b1);

      // Enable dropped right after a burst starts: burst completes, no new request.
      found = 0;
      for (int i = 0; i < 300 && found == 0; i++) begin
         if (m_active[0] && m_p[0] >= 1) found = 1;
         else step(1'b1, 1'b1);
      end
      chk("endrop_wait", found, 1);
      repeat (200) step(1'b0, 1'b1);
      chk("endrop_req_a", ifa.ref_req, 0);
      chk("endrop_busy_a", ifa.ref_busy, 0);

      // Random enable and grant.
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0));
      end

      // Asynchronous reset in the middle of a TRFC wait.
      found = 0;
      for (int i = 0; i < 1000 && found == 0; i++) begin
         if (m_active[0] && m_p[0] > TRP && m_next_ref[0] < 0 && m_done_p[0] < 0) found = 1;
         else step(1'b1, 1'b1);
      end
      chk("rst_wait", found, 1);
      if (found != 0) begin
         soft_rst_n = 1'b0;
         #1;
         chk("midrst_a", {7'd0, obs_a}, {7'd0, RESET_VEC});
         chk("midrst_b", {7'd0, obs_b}, {7'd0, RESET_VEC});
         model_reset();
         @(negedge clk);
         soft_rst_n = 1'b1;
         repeat (250) step(1'b1, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
